// File: rtl/wb_sram_responder.sv
// Wishbone B4 pipelined SRAM slave with fixed-latency, in-order ack/err responses.
// Optional macro WB_SRAM_ERR_EN: out-of-range accesses answer err instead of aliasing.
module wb_sram_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 1,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] adr,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack,
    output logic        err,
    output logic        stall
);
    localparam int WORDS = 1 << ADDR_WIDTH;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [31:0]           mem [WORDS];
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  accept;
    logic                  leaving;
    logic [CNT_W-1:0]      cnt;
    logic [LATENCY:0]      pipe_valid;
    logic [LATENCY:0]      pipe_err;
    logic [31:0]           pipe_data [LATENCY+1];
    logic                  unused_offset_bits;

    assign offset   = adr - BASE_ADDR;
    assign word_idx = offset[ADDR_WIDTH+1:2];

`ifdef WB_SRAM_ERR_EN
    assign in_range = (offset >> (ADDR_WIDTH + 2)) == 32'd0;
`else
    assign in_range = 1'b1;
`endif

    // Byte lane and high offset bits only matter for the range check.
    assign unused_offset_bits = ^{offset[31:ADDR_WIDTH+2], offset[1:0]};

    // A departing response frees its slot in the same cycle; stall never looks at stb/adr.
    assign leaving = pipe_valid[LATENCY];
    assign stall   = (cnt == CNT_MAX) && !leaving;
    assign accept  = cyc && stb && !stall;

    always_ff @(posedge clk) begin
        if (!rst && accept && we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    mem[word_idx][8*i +: 8] <= dat_i[8*i +: 8];
                end
            end
        end
    end

    // Dropping cyc abandons every pending response of the aborted bus cycle.
    always_ff @(posedge clk) begin
        if (rst || !cyc) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && !in_range;
            pipe_data[0]  <= (accept && !we && in_range) ? mem[word_idx] : 32'd0;
            for (int k = 1; k <= LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_err[k]   <= pipe_err[k-1];
                pipe_data[k]  <= pipe_data[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !cyc) begin
            cnt <= '0;
        end else if (accept && !leaving) begin
            cnt <= cnt + 1'b1;
        end else if (!accept && leaving) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign ack   = pipe_valid[LATENCY] && !pipe_err[LATENCY];
    assign err   = pipe_valid[LATENCY] && pipe_err[LATENCY];
    assign dat_o = ack ? pipe_data[LATENCY] : 32'd0;

endmodule

// File: doc/wb_sram_responder.md
# wb_sram_responder

Wishbone B4 pipelined slave: a single-port word-addressed SRAM answering requests issued by a master through the shared-bus interconnect. Accepts one request per cycle, returns `ack`/`err` in order after a fixed, parameterised latency, and throttles masters with `stall` when its outstanding-request limit is reached. Sits on one slave port of the interconnect; one instance per memory region.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte base address of the region, aligned to 4·2^`ADDR_WIDTH`
- `ADDR_WIDTH`, 10, log2 of memory depth in 32-bit words (1..16)
- `LATENCY`, 1, extra wait cycles between acceptance and response (0..7)
- `DEPTH`, 2, maximum outstanding (accepted, not yet responded) requests (1..8)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cyc`  in  1  bus cycle in progress
- `stb`  in  1  request strobe
- `we`  in  1  1 = write, 0 = read
- `sel`  in  4  byte enables, bit i ↔ `dat_i[8i+7:8i]`
- `adr`  in  32  byte address
- `dat_i`  in  32  write data
- `dat_o`  out  32  read data, valid with `ack`
- `ack`  out  1  successful response, one cycle per request
- `err`  out  1  error response, one cycle per request
- `stall`  out  1  request not accepted this cycle

## Operation
- Accept: `cyc & stb & !stall` at a rising edge. Offset = `adr - BASE_ADDR`; word index = offset[`ADDR_WIDTH`+1:2]; offset[1:0] ignored.
- In range: offset < 4·2^`ADDR_WIDTH` (unsigned). Write: bytes with `sel[i]`=1 updated at the accepting edge; `sel`=0 is a legal no-op write acked normally. Read: full word captured at the accepting edge, `sel` ignored.
- Out of range (macro on): no memory access, response is `err`.
- Response pipeline: LATENCY+1 stages of {valid, is_err, data}; shifts every cycle; final stage drives outputs. Strictly in order, at most one response per cycle, `ack` and `err` never both 1.
- `dat_o` = captured read data with `ack` on reads; 0 on write acks, on `err`, and when idle.
- Outstanding counter `cnt` (0..DEPTH): +1 on accept, −1 on response, unchanged when both occur together.
- `stall` = (`cnt` == DEPTH) & !(response leaving this cycle) — combinational; a departing response frees a slot same cycle.
- `cyc` low: all pipeline valids cleared next edge, `cnt` ← 0, no further `ack`/`err` for that cycle; writes already accepted stay committed. `stb` without `cyc` ignored.
- Write then read to same word on consecutive accepts: read returns new data (write commits at its edge, read samples next edge).

## Timing
- Reset (`rst`=1 at edge): `ack`=0, `err`=0, `dat_o`=0, `stall`=0, `cnt`=0, pipeline cleared. Memory contents not reset and undefined until written. `rst` mid-transfer discards all pending responses.
- Latency: request accepted at edge n → `ack`/`err` high during cycle n+1+LATENCY (registered output).
- Throughput: 1 request/cycle sustained when DEPTH ≥ LATENCY+1; otherwise `stall` rises after DEPTH back-to-back accepts.
- `stall` may change combinationally only with `cnt` and the pipeline head; no dependency on `stb`/`adr` (no combinational loop through the interconnect).

## Configuration
- `WB_SRAM_ERR_EN` defined: out-of-range accepts produce `err`, memory untouched.
- Undefined: no range check; offset is taken modulo 4·2^`ADDR_WIDTH` (aliasing), every request acked, `err` tied 0.

## Test plan
- Reset: hold `rst` 2 cycles mid-burst → `ack`=`err`=`stall`=0, `dat_o`=0, no stray responses after release.
- Single write/read, LATENCY=1, BASE_ADDR=0x1000: write 0xDEADBEEF to 0x1004 `sel`=4'hF → `ack` 2 cycles after accept; read 0x1004 → `ack` with `dat_o`=0xDEADBEEF.
- Byte enables: word holds 0x11223344, write 0xAABBCCDD `sel`=4'b0101 → readback 0x11BB33DD.
- Back-to-back: LATENCY=1, DEPTH=2, 8 consecutive reads → `stall` never asserted, 8 acks on consecutive cycles in order; same with DEPTH=1 → `stall` every other cycle, 8 acks total.
- Out of range (macro on): read `BASE_ADDR`+4·2^`ADDR_WIDTH` → `err` at n+2, `ack`=0, `dat_o`=0; macro off → `ack` with data of word 0.
- Abort: 2 reads accepted, `cyc` dropped next cycle → no `ack`/`err` afterwards, `cnt`=0, next request accepted without stall.
